ps2_kbd_rx: RTL

Parametrised PS/2 keyboard receiver, successor to the existing `ps2_keyboard` block. It synchronises the PS/2 clock and data lines, deframes 11-bit frames, and checks start, odd parity and stop bits. It decodes `E0`/`F0` prefixes into tagged key events and buffers them in a configurable FIFO. It sits between the board PS/2 pins and the keyboard consumer (display/ASCII logic), and keeps the `ready`/`nextdata_n`/`overflow` handshake of the earlier block.

---
 rtl/ps2_pkg.sv | 21 ++
 rtl/ps2_kbd_rx_if.sv | 27 ++
 rtl/ps2_evt_fifo.sv | 61 ++++++
 rtl/ps2_kbd_rx.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: prefix codes, frame length, key event type and frame check.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
    localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;
    localparam int         PS2_FRAME_BITS = 11;

    // One decoded key event as stored in the FIFO.
    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_evt_t;

    // Frame layout, index 0 first on the wire: start, d0..d7, parity, stop.
    // Good when start=0, stop=1 and data+parity carry an odd number of ones.
    function automatic logic ps2_frame_ok(input logic [10:0] frame);
        return (frame[0] == 1'b0) && (frame[10] == 1'b1) && (^frame[9:1] == 1'b1);
    endfunction

endpackage

// File: rtl/ps2_kbd_rx_if.sv
// Consumer-side handshake of the PS/2 keyboard receiver.
interface ps2_kbd_rx_if #(
    parameter int FIFO_DEPTH = 8
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          nextdata_n;
    logic [7:0]    data;
    logic          ext;
    logic          brk;
    logic          ready;
    logic          overflow;
    logic          frame_err;
    logic [CW-1:0] count;

    // Receiver side: drives the event head and status, listens to the pop strobe.
    modport master (
        output data, ext, brk, ready, overflow, frame_err, count,
        input  nextdata_n
    );

    // Consumer side.
    modport slave (
        input  data, ext, brk, ready, overflow, frame_err, count,
        output nextdata_n
    );
endinterface

// File: rtl/ps2_evt_fifo.sv
// Small synchronous FIFO with a combinational head; a pop frees room for a same-cycle push.
module ps2_evt_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_pop;
    logic             do_push;

    assign full    = (count_reg == FULL_CNT);
    assign empty   = (count_reg == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign count   = count_reg;
    // Head reads as zero when empty so the outputs are clean after reset.
    assign head    = empty ? '0 : mem[rd_ptr_reg];

    // Storage write; contents need no reset since occupancy gates the head.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end
endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchroniser, 11-bit deframer with timeout, E0/F0 decoder, event FIFO.
module ps2_kbd_rx
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ps2_clk,
    input  logic          ps2_data,
    input  logic          raw_mode,
    ps2_kbd_rx_if.master  bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;

    localparam int          TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  LAST_BIT = 4'(PS2_FRAME_BITS - 1);

    logic [SYNC_STAGES-1:0] clk_sync_reg;
    logic [SYNC_STAGES-1:0] data_sync_reg;
    logic                   clk_prev_reg;
    logic                   clk_s;
    logic                   data_s;
    logic                   fall;

    logic [1:0]    state_reg;
    logic [3:0]    bit_cnt_reg;
    logic [10:0]   frame_reg;
    logic [TW-1:0] to_cnt_reg;
    logic          timeout;
    logic          good;
    logic [7:0]    code;
    logic          ext_pend_reg;
    logic          brk_pend_reg;
    logic          frame_err_reg;
    logic          overflow_reg;

    logic          fifo_push;
    ps2_evt_t      push_evt;
    ps2_evt_t      head_evt;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    // Synchronisers idle high, matching an undriven PS/2 bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_reg  <= '1;
            data_sync_reg <= '1;
            clk_prev_reg  <= 1'b1;
        end else begin
            clk_sync_reg  <= {clk_sync_reg[SYNC_STAGES-2:0], ps2_clk};
            data_sync_reg <= {data_sync_reg[SYNC_STAGES-2:0], ps2_data};
            clk_prev_reg  <= clk_s;
        end
    end

    assign clk_s   = clk_sync_reg[SYNC_STAGES-1];
    assign data_s  = data_sync_reg[SYNC_STAGES-1];
    assign fall    = clk_prev_reg && !clk_s;
    assign timeout = (state_reg == ST_SHIFT) && !fall && (to_cnt_reg == TO_LAST);
    assign good    = ps2_frame_ok(frame_reg);
    assign code    = frame_reg[8:1];

    // Deframer: shift bits in from the top so the start bit lands at index 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            bit_cnt_reg   <= '0;
            frame_reg     <= '0;
            to_cnt_reg    <= '0;
            frame_err_reg <= 1'b0;
        end else begin
            frame_err_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (fall) begin
                        frame_reg   <= {data_s, frame_reg[10:1]};
                        bit_cnt_reg <= 4'd1;
                        to_cnt_reg  <= '0;
                        state_reg   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (fall) begin
                        frame_reg   <= {data_s, frame_reg[10:1]};
                        bit_cnt_reg <= bit_cnt_reg + 4'd1;
                        to_cnt_reg  <= '0;
                        if (bit_cnt_reg == LAST_BIT) begin
                            state_reg <= ST_CHECK;
                        end
                    end else if (timeout) begin
                        frame_err_reg <= 1'b1;
                        bit_cnt_reg   <= '0;
                        to_cnt_reg    <= '0;
                        state_reg     <= ST_IDLE;
                    end else begin
                        to_cnt_reg <= to_cnt_reg + TW'(1);
                    end
                end
                ST_CHECK: begin
                    frame_err_reg <= !good;
                    bit_cnt_reg   <= '0;
                    state_reg     <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Prefix tracking; any bad frame, timeout or raw byte forgets pending prefixes.
    always_ff @(posedge clk) begin
        if (rst || timeout) begin
            ext_pend_reg <= 1'b0;
            brk_pend_reg <= 1'b0;
        end else if (state_reg == ST_CHECK) begin
            if (!good || raw_mode) begin
                ext_pend_reg <= 1'b0;
                brk_pend_reg <= 1'b0;
            end else if (code == PS2_EXT_PREFIX) begin
                ext_pend_reg <= 1'b1;
            end else if (code == PS2_BRK_PREFIX) begin
                brk_pend_reg <= 1'b1;
            end else begin
                ext_pend_reg <= 1'b0;
                brk_pend_reg <= 1'b0;
            end
        end
    end

    // Event build: prefixes are swallowed unless raw mode is on.
    always_comb begin
        fifo_push     = 1'b0;
        push_evt.ext  = 1'b0;
        push_evt.brk  = 1'b0;
        push_evt.code = code;
        if (state_reg == ST_CHECK && good) begin
            if (raw_mode) begin
                fifo_push = 1'b1;
            end else if (code != PS2_EXT_PREFIX && code != PS2_BRK_PREFIX) begin
                fifo_push    = 1'b1;
                push_evt.ext = ext_pend_reg;
                push_evt.brk = brk_pend_reg;
            end
        end
    end

    assign fifo_pop = !bus.nextdata_n;

    // Sticky drop flag; a concurrent pop makes room, so that case is not a drop.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_reg <= 1'b0;
        end else if (fifo_push && fifo_full && !fifo_pop) begin
            overflow_reg <= 1'b1;
        end
    end

    ps2_evt_fifo #(
        .WIDTH ($bits(ps2_evt_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (push_evt),
        .pop       (fifo_pop),
        .head      (head_evt),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign bus.data      = head_evt.code;
    assign bus.ext       = head_evt.ext;
    assign bus.brk       = head_evt.brk;
    assign bus.ready     = !fifo_empty;
    assign bus.count     = fifo_count;
    assign bus.overflow  = overflow_reg;
    assign bus.frame_err = frame_err_reg;
endmodule
